// File: rtl/ex_div_ctrl.sv
// Radix-2 restoring divider sequencer for EX DIV/DIVU; result {rem, quo} held while ready_o.
// Latency: 32 step cycles after the FREE start cycle (divide-by-zero: 2 cycles); result registered.
// Backpressure: stall_req_o holds the pipeline until ready_o; END is held until EX drops start_i.
module ex_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_div_i,
    input  logic        annul_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic        dvd_neg_q;
    logic        dvs_neg_q;
    logic        sgn_q;
    logic [63:0] res_q;

    logic        op1_neg;
    logic        op2_neg;
    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [33:0] shifted;
    logic [33:0] trial;
    logic        trial_ge;
    logic [32:0] new_rem;
    logic [31:0] new_quo;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;
    logic        last_step;

    assign op1_neg = signed_div_i & opdata1_i[31];
    assign op2_neg = signed_div_i & opdata2_i[31];
    assign op1_abs = op1_neg ? (32'd0 - opdata1_i) : opdata1_i;
    assign op2_abs = op2_neg ? (32'd0 - opdata2_i) : opdata2_i;

    // Partial remainder shifted left with the next dividend bit brought in from the top.
    assign shifted  = {work_q[64:32], dvd_q[31]};
    assign trial    = shifted - {2'b00, dvs_q};
    assign trial_ge = ~trial[33];
    assign new_rem  = trial_ge ? trial[32:0] : shifted[32:0];
    assign new_quo  = {work_q[30:0], trial_ge};

    assign quo_fin = (sgn_q & (dvd_neg_q ^ dvs_neg_q)) ? (32'd0 - new_quo) : new_quo;
    assign rem_fin = (sgn_q & dvd_neg_q) ? (32'd0 - new_rem[31:0]) : new_rem[31:0];

    assign last_step = (cnt_q == 6'd31);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    state_d = (opdata2_i == 32'd0) ? DIVZERO : ON;
                end
            end
            DIVZERO: state_d = annul_i ? FREE : END;
            ON: begin
                if (annul_i) begin
                    state_d = FREE;
                end else if (last_step) begin
                    state_d = END;
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            dvd_q     <= 32'd0;
            dvs_q     <= 32'd0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            sgn_q     <= 1'b0;
            res_q     <= 64'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                FREE: begin
                    if (start_i && !annul_i && (opdata2_i != 32'd0)) begin
                        dvd_q     <= op1_abs;
                        dvs_q     <= op2_abs;
                        dvd_neg_q <= op1_neg;
                        dvs_neg_q <= op2_neg;
                        sgn_q     <= signed_div_i;
                        work_q    <= 65'd0;
                        cnt_q     <= 6'd0;
                    end
                end
                DIVZERO: res_q <= 64'd0;
                ON: begin
                    if (!annul_i) begin
                        work_q <= {new_rem, new_quo};
                        dvd_q  <= {dvd_q[30:0], 1'b0};
                        cnt_q  <= cnt_q + 6'd1;
                        if (last_step) begin
                            res_q <= {rem_fin, quo_fin};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by state so FREE and reset both present zero immediately.
    assign ready_o     = (state_q == END);
    assign result_o    = ready_o ? res_q : 64'd0;
    assign stall_req_o = start_i & ~ready_o & ~annul_i;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed and random checks of ex_div_ctrl: results, stall length, annul and async reset.
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_div_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb_q[$];

    ex_div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .annul_i      (annul_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stall_req_o  (stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Waits for ready_o with start_i held, scrambling operands once they should be latched.
    task automatic wait_result(input string tag, input int exp_stall);
        int          stall_cnt;
        bit          got;
        logic [63:0] exp;
        stall_cnt = 0;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ready_o) begin
                got = 1'b1;
                break;
            end
            if (stall_req_o) stall_cnt++;
            if (c >= 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
        end
        chk({tag, " ready"}, 64'(got), 64'd1);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
        if (got) begin
            chk({tag, " result"}, result_o, exp);
            chk({tag, " stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
            chk({tag, " stall_released"}, 64'(stall_req_o), 64'd0);
        end
        @(posedge clk);
        #1 start_i = 1'b0;
        @(negedge clk);
        chk({tag, " end_hold"}, 64'(ready_o), 64'd1);
        @(negedge clk);
        chk({tag, " free_ready"}, 64'(ready_o), 64'd0);
        chk({tag, " free_result"}, result_o, 64'd0);
    endtask

    task automatic do_div(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_stall);
        @(posedge clk);
        #1;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb_q.push_back(exp_res);
        wait_result(tag, exp_stall);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          saw_ready;
        logic [31:0] ra, rb;
        bit          rs;

        #1;
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        chk("reset stall", 64'(stall_req_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        do_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        do_div("div -100/7", 1'b1, 32'hFFFFFF9C, 32'h7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33);
        do_div("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
        do_div("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33);
        do_div("divu 5/9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33);
        do_div("divu x/0", 1'b0, 32'h12345678, 32'd0, 64'h0, 2);
        do_div("div x/0", 1'b1, 32'h87654321, 32'd0, 64'h0, 2);
        do_div("div 100/-7", 1'b1, 32'd100, 32'hFFFFFFF9, {32'd2, 32'hFFFFFFF2}, 33);

        // Annul partway through the step sequence.
        @(posedge clk);
        #1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (11) @(negedge clk);
        #1 annul_i = 1'b1;
        #1;
        chk("annul stall_drop", 64'(stall_req_o), 64'd0);
        chk("annul ready", 64'(ready_o), 64'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        saw_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready_o) saw_ready = 1'b1;
        end
        chk("annul no_ready", 64'(saw_ready), 64'd0);
        do_div("divu 50/5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);

        // Asynchronous reset mid-division with start_i held across release.
        @(posedge clk);
        #1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1234;
        opdata2_i    = 32'd10;
        start_i      = 1'b1;
        repeat (21) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst ready", 64'(ready_o), 64'd0);
        chk("rst result", result_o, 64'd0);
        chk("rst stall_held", 64'(stall_req_o), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        sb_q.push_back({32'd4, 32'd123});
        wait_result("post-rst 1234/10", 33);

        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (rb == 32'd0) rb = 32'd3;
            do_div($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb), 33);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Multi-cycle 32-bit integer divider sequencer for the EX stage of the five-stage pipeline. Accepts a DIV/DIVU request from EX, runs a radix-2 restoring division over 32 cycles, and raises a stall request that the pipeline stall controller turns into a freeze of PC, IF/ID, ID and EX. It returns a 64-bit {remainder, quotient} result for the HI/LO write path.

## Interface

Parameters:
- none (width fixed at 32 bits)

Ports:
- clk  input  1  pipeline clock; all state on rising edge
- rst  input  1  asynchronous reset, active-low
- start_i  input  1  EX requests a division; held high by EX while stalled
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU
- annul_i  input  1  cancel in-flight division (exception/flush)
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- result_o  output  64  {remainder[63:32], quotient[31:0]}; valid while ready_o = 1
- ready_o  output  1  result valid
- stall_req_o  output  1  to stall controller's EX request; combinational = start_i & ~ready_o & ~annul_i

## Operation

- States: FREE, DIVZERO, ON, END.
- FREE: if start_i & ~annul_i: opdata2_i == 0 → DIVZERO; else latch |dividend|, |divisor| (two's-complement abs when signed_div_i, raw otherwise), latch signs and signed_div_i, clear 65-bit working register and 6-bit counter → ON. Otherwise stay.
- ON: one restoring step per cycle: shift working register left 1, trial-subtract divisor from upper 33 bits; non-negative → keep difference, quotient bit 1; else quotient bit 0. Counter increments. Step with counter == 31 is the last → END.
- Entering END from ON: signed and dividend/divisor signs differ → quotient negated; signed and dividend negative → remainder negated. Arithmetic modulo 2^32, no overflow flag.
- DIVZERO: result forced to 64'h0 → END next cycle.
- END: result_o holds final value, ready_o = 1. Leaves to FREE when start_i = 0; result_o and ready_o return to 0 in FREE.
- annul_i = 1 in ON or DIVZERO → FREE next cycle, no result, ready_o stays 0. annul_i in END → FREE.
- Operands are latched only in FREE; changes on opdata*_i during ON/END are ignored.
- start_i dropped during ON (without annul) → division continues; result discarded when FREE is re-entered after END.

## Timing

- Reset (rst = 0, asynchronous): state FREE, counter 0, working register 0, result_o = 64'h0, ready_o = 0; stall_req_o = 0 only if start_i = 0 (it is combinational).
- Reset deassertion mid-division: restart from FREE; a held start_i begins a fresh division next edge.
- Normal latency: start_i sampled at edge T in FREE → ON for edges T+1..T+32 → ready_o = 1 after edge T+33. stall_req_o high from cycle T through T+32 (33 cycles), low from T+33.
- Divide-by-zero: DIVZERO after T+1, END after T+2; ready_o high 2 cycles after start.
- EX consumes result in the cycle ready_o = 1 (stall released), drops start_i next cycle; block is FREE one cycle later and accepts a back-to-back start at that edge.
- annul_i asserted at cycle k of ON → FREE after edge k+1, stall_req_o low in cycle k.

## Test plan

- DIVU 100 / 7: start held → stall_req_o high 33 cycles, ready_o at T+33, result_o = {32'd2, 32'd14}.
- DIV -100 / 7 (0xFFFFFF9C / 0x7): result_o = {32'hFFFFFFFE, 32'hFFFFFFF2}; DIV 0x80000000 / 0xFFFFFFFF → {32'h0, 32'h80000000}.
- DIVU 0xFFFFFFFF / 1 → {32'h0, 32'hFFFFFFFF}; DIVU 5 / 9 → {32'd5, 32'd0}.
- Divide by zero (any dividend, both modes): ready_o two cycles after start, result_o = 64'h0.
- annul_i pulsed at ON cycle 10: stall_req_o drops same cycle, FREE after next edge, ready_o never asserts; following DIVU 50 / 5 → {0, 10} with full 33-cycle latency.
- rst pulled low at ON cycle 20: outputs 0 immediately; after release with start_i held, new division completes 33 cycles later with correct result.
